rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: ALU path (A) and load/memory path (M).
- Each requester has its own small queue with a valid/ready handshake.
- The arbiter issues at most one register write per cycle. It keeps write-after-write order to the same rd and reports pending writes for hazard detection.
- Sits between the execute/memory stages and the register file, and drives its rd, rd_din and write_enable inputs.

---
 rtl/rf_wb_arbiter_pkg.sv | 31 +++
 rtl/rf_wb_arbiter_queue.sv | 63 ++++++
 rtl/rf_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared types and the arrival-tag age compare for rf_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int TAG_MAX_W = 8;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
        logic [TAG_MAX_W-1:0] tag;
    } wb_entry_t;

    // True when this_tag was issued before other_tag, modulo 2^tag_w.
    function automatic logic tag_is_older(input logic [TAG_MAX_W-1:0] this_tag,
                                          input logic [TAG_MAX_W-1:0] other_tag,
                                          input int                   tag_w);
        logic [TAG_MAX_W-1:0] w_mask;
        logic [TAG_MAX_W-1:0] w_diff;
        w_mask = TAG_MAX_W'((1 << tag_w) - 1);
        w_diff = (other_tag - this_tag) & w_mask;
        return (w_diff != '0) && (32'(w_diff) < (32'd1 << (tag_w - 1)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : DEPTH-entry writeback FIFO exposing head, count and per-entry rd.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_queue
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_push,
    input  wb_entry_t                         i_entry,
    input  logic                              i_pop,
    output wb_entry_t                         o_head,
    output logic [$clog2(DEPTH):0]            o_count,
    output logic [DEPTH-1:0]                  o_entry_valid,
    output logic [DEPTH-1:0][RF_ADDR_W-1:0]   o_entry_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] w_offset;
        assign w_offset         = PTR_W'(i) - r_rd_ptr;
        assign o_entry_valid[i] = ({1'b0, w_offset} < r_count);
        assign o_entry_rd[i]    = r_mem[i].rd;
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Arbitrates ALU and load writebacks onto one register-file port.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [RF_ADDR_W-1:0] a_rd,
    input  logic [RF_DATA_W-1:0] a_data,
    output logic                 a_ready,
    input  logic                 m_valid,
    input  logic [RF_ADDR_W-1:0] m_rd,
    input  logic [RF_DATA_W-1:0] m_data,
    output logic                 m_ready,
    output logic [RF_ADDR_W-1:0] rf_rd,
    output logic [RF_DATA_W-1:0] rf_rd_din,
    output logic                 rf_write_enable,
    input  logic [RF_ADDR_W-1:0] q_rs1,
    input  logic [RF_ADDR_W-1:0] q_rs2,
    output logic                 pending_rs1,
    output logic                 pending_rs2,
    output logic                 busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [TAG_W-1:0]               r_tag;
    logic                           r_prio_m;
    wb_entry_t                      w_a_entry, w_m_entry, w_a_head, w_m_head;
    logic [CNT_W-1:0]               w_a_count, w_m_count;
    logic [DEPTH-1:0]               w_a_ev, w_m_ev;
    logic [DEPTH-1:0][RF_ADDR_W-1:0] w_a_erd, w_m_erd;
    logic                           w_a_push, w_m_push;
    logic                           w_a_hv, w_m_hv, w_contend;
    logic                           w_grant_a, w_grant_m;

    assign a_ready  = !reset && (w_a_count < CNT_W'(DEPTH));
    assign m_ready  = !reset && (w_m_count < CNT_W'(DEPTH));
    assign w_a_push = a_valid && a_ready;
    assign w_m_push = m_valid && m_ready;

    always_comb begin
        w_a_entry      = '0;
        w_a_entry.rd   = a_rd;
        w_a_entry.data = a_data;
        w_a_entry.tag  = TAG_MAX_W'(r_tag);
        w_m_entry      = '0;
        w_m_entry.rd   = m_rd;
        w_m_entry.data = m_data;
        w_m_entry.tag  = TAG_MAX_W'(TAG_W'(r_tag + TAG_W'(w_a_push)));
    end

    wb_queue #(.DEPTH(DEPTH)) u_a_queue (
        .clk(clk), .reset(reset), .i_push(w_a_push), .i_entry(w_a_entry), .i_pop(w_grant_a),
        .o_head(w_a_head), .o_count(w_a_count), .o_entry_valid(w_a_ev), .o_entry_rd(w_a_erd)
    );

    wb_queue #(.DEPTH(DEPTH)) u_m_queue (
        .clk(clk), .reset(reset), .i_push(w_m_push), .i_entry(w_m_entry), .i_pop(w_grant_m),
        .o_head(w_m_head), .o_count(w_m_count), .o_entry_valid(w_m_ev), .o_entry_rd(w_m_erd)
    );

    assign w_a_hv    = !reset && (w_a_count != '0);
    assign w_m_hv    = !reset && (w_m_count != '0);
    assign w_contend = w_a_hv && w_m_hv;

    // Same rd must retire in arrival order; otherwise alternate between sides.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_m = 1'b0;
        if (w_contend) begin
            if (w_a_head.rd == w_m_head.rd) begin
                if (tag_is_older(w_a_head.tag, w_m_head.tag, TAG_W)) w_grant_a = 1'b1;
                else                                                 w_grant_m = 1'b1;
            end else if (r_prio_m) begin
                w_grant_m = 1'b1;
            end else begin
                w_grant_a = 1'b1;
            end
        end else if (w_a_hv) begin
            w_grant_a = 1'b1;
        end else if (w_m_hv) begin
            w_grant_m = 1'b1;
        end
    end

    always_comb begin
        rf_rd     = '0;
        rf_rd_din = '0;
        if (w_grant_a) begin
            rf_rd     = w_a_head.rd;
            rf_rd_din = w_a_head.data;
        end else if (w_grant_m) begin
            rf_rd     = w_m_head.rd;
            rf_rd_din = w_m_head.data;
        end
        rf_write_enable = (w_grant_a || w_grant_m) && (rf_rd != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag    <= '0;
            r_prio_m <= 1'b0;
        end else begin
            r_tag <= r_tag + TAG_W'(w_a_push) + TAG_W'(w_m_push);
            if (w_contend) begin
                r_prio_m <= w_grant_a;
            end
        end
    end

    always_comb begin
        pending_rs1 = 1'b0;
        pending_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((w_a_ev[i] && w_a_erd[i] == q_rs1) || (w_m_ev[i] && w_m_erd[i] == q_rs1)) pending_rs1 = 1'b1;
            if ((w_a_ev[i] && w_a_erd[i] == q_rs2) || (w_m_ev[i] && w_m_erd[i] == q_rs2)) pending_rs2 = 1'b1;
        end
        pending_rs1 = pending_rs1 && (q_rs1 != '0);
        pending_rs2 = pending_rs2 && (q_rs2 != '0);
    end

    assign busy = (w_a_count != '0) || (w_m_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Directed and random stimulus against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, m_valid = 1'b0;
    logic [4:0]  a_rd = '0, m_rd = '0, q_rs1 = '0, q_rs2 = '0;
    logic [31:0] a_data = '0, m_data = '0;
    logic        a_ready, m_ready, rf_write_enable, pending_rs1, pending_rs2, busy;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_din;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DEPTH(DEPTH), .TAG_W(3)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .rf_rd(rf_rd), .rf_rd_din(rf_rd_din), .rf_write_enable(rf_write_enable),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .pending_rs1(pending_rs1), .pending_rs2(pending_rs2),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          seq;
    } mentry_t;

    mentry_t qa[$];
    mentry_t qm[$];
    int      seq_ctr = 0;
    bit      prio_m  = 1'b0;

    // Register file as written by the DUT, for end-of-sequence value checks.
    logic [31:0] dut_rf [32];
    always @(posedge clk) if (rf_write_enable) dut_rf[rf_rd] <= rf_rd_din;

    function automatic bit has_rd(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (qa[i]) if (qa[i].rd == q) return 1'b1;
        foreach (qm[i]) if (qm[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic [4:0] q1, input logic [4:0] q2);
        bit          e_ra, e_rm, ga, gm, both;
        logic [4:0]  e_rd;
        logic [31:0] e_din;
        mentry_t     ne;
        @(negedge clk);
        reset = rst; a_valid = av; a_rd = ard; a_data = ad;
        m_valid = mv; m_rd = mrd; m_data = md; q_rs1 = q1; q_rs2 = q2;
        #1;
        e_ra = !rst && (qa.size() < DEPTH);
        e_rm = !rst && (qm.size() < DEPTH);
        ga = 1'b0; gm = 1'b0;
        both = (qa.size() > 0) && (qm.size() > 0);
        if (!rst) begin
            if (both) begin
                if (qa[0].rd == qm[0].rd) begin
                    if (qa[0].seq < qm[0].seq) ga = 1'b1; else gm = 1'b1;
                end else if (prio_m) gm = 1'b1;
                else ga = 1'b1;
            end else if (qa.size() > 0) ga = 1'b1;
            else if (qm.size() > 0) gm = 1'b1;
        end
        e_rd  = ga ? qa[0].rd   : (gm ? qm[0].rd   : 5'd0);
        e_din = ga ? qa[0].data : (gm ? qm[0].data : 32'd0);
        check_value("a_ready", a_ready, e_ra);
        check_value("m_ready", m_ready, e_rm);
        check_value("rf_write_enable", rf_write_enable, (ga || gm) && e_rd != 5'd0);
        check_value("rf_rd", rf_rd, e_rd);
        check_value("rf_rd_din", rf_rd_din, e_din);
        check_value("pending_rs1", pending_rs1, has_rd(q1));
        check_value("pending_rs2", pending_rs2, has_rd(q2));
        check_value("busy", busy, (qa.size() + qm.size()) != 0);
        @(posedge clk);
        if (rst) begin
            qa.delete(); qm.delete(); prio_m = 1'b0;
        end else begin
            if (!rst && both) prio_m = ga;
            if (ga) void'(qa.pop_front());
            if (gm) void'(qm.pop_front());
            if (av && e_ra) begin ne.rd = ard; ne.data = ad; ne.seq = seq_ctr++; qa.push_back(ne); end
            if (mv && e_rm) begin ne.rd = mrd; ne.data = md; ne.seq = seq_ctr++; qm.push_back(ne); end
        end
    endtask

    task automatic idle(input int n, input logic [4:0] q1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, q1, 0);
    endtask

    initial begin
        @(posedge clk);
        step(1, 1, 5, 32'h1, 1, 6, 32'h2, 5, 6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single ALU write, then busy drops.
        step(0, 1, 5, 32'h1234, 0, 0, 0, 5, 0);
        idle(3, 5);

        // Both sides saturated with distinct rd.
        for (int i = 0; i < 4; i++) step(0, 1, 3, 32'hA, 1, 4, 32'hB, 3, 4);
        idle(6, 3);

        // Same rd in the same cycle, then M one cycle ahead of A.
        step(0, 1, 7, 32'd1, 1, 7, 32'd2, 7, 0);
        idle(3, 7);
        check_value("r7_same_cycle", dut_rf[7], 32'd2);
        step(0, 0, 0, 0, 1, 7, 32'd3, 7, 0);
        step(0, 1, 7, 32'd4, 0, 0, 0, 7, 0);
        idle(3, 7);
        check_value("r7_m_first", dut_rf[7], 32'd4);

        // Writes to x0 consume a slot without a strobe.
        step(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
        idle(2, 0);

        // A fills up behind contention; extra A requests are dropped.
        for (int i = 0; i < 6; i++) step(0, 1, 5'(9 + i), 32'(100 + i), 1, 5'(20 + i), 32'(200 + i), 9, 21);
        idle(8, 10);

        // Reset with both queues full, then same-rd ordering after tag restart.
        for (int i = 0; i < 3; i++) step(0, 1, 5'(11 + i), 32'(i), 1, 5'(12 + i), 32'(50 + i), 11, 12);
        step(1, 1, 1, 32'h5, 1, 2, 32'h6, 11, 12);
        idle(1, 11);
        step(0, 1, 7, 32'h77, 1, 7, 32'h88, 7, 0);
        idle(3, 7);
        check_value("r7_after_reset", dut_rf[7], 32'h88);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
